// File: rtl/mem_port_arbiter.sv
// Two-port arbiter that hands the banked main memory to the I-cache (port 0) or the D-cache (port 1)
// for whole transactions, with round-robin fairness, drain-before-handoff and a hold watchdog.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NBANK    = 4,
  parameter int unsigned PRIO_RST = 0,
  parameter int unsigned MAX_HOLD = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              rd0,
  input  logic              rd1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              stall0,
  output logic              stall1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [NBANK-1:0]  busy0,
  output logic [NBANK-1:0]  busy1,
  output logic              err0,
  output logic              err1,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_data_in,
  output logic              m_rd,
  output logic              m_wr,
  input  logic [DATA_W-1:0] m_data_out,
  input  logic [NBANK-1:0]  m_busy,
  input  logic              m_err
);

  localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(MAX_HOLD);

  typedef enum logic [2:0] {StIdle, StGrant0, StGrant1, StDrain0, StDrain1} state_e;

  state_e           state_q, state_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic [HoldW-1:0] hold_q, hold_d;

  logic own0, own1, grant0, grant1, watchdog;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      rr_ptr_q <= 1'(PRIO_RST);
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      hold_q   <= hold_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      StIdle: begin
        if (req0 && req1)  state_d = rr_ptr_q ? StGrant1 : StGrant0;
        else if (req0)     state_d = StGrant0;
        else if (req1)     state_d = StGrant1;
      end
      StGrant0: if (!req0) state_d = StDrain0;
      StGrant1: if (!req1) state_d = StDrain1;
      StDrain0: begin
        if (m_busy == '0) begin
          rr_ptr_d = 1'b1;
          if (req1)      state_d = StGrant1;
          else if (req0) state_d = StGrant0;
          else           state_d = StIdle;
        end
      end
      StDrain1: begin
        if (m_busy == '0) begin
          rr_ptr_d = 1'b0;
          if (req0)      state_d = StGrant0;
          else if (req1) state_d = StGrant1;
          else           state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Counter restarts on every entry into a grant and saturates while the grant persists.
  always_comb begin
    hold_d = '0;
    if ((state_d == StGrant0 || state_d == StGrant1) && state_d == state_q) begin
      hold_d = (hold_q == HoldMax) ? hold_q : hold_q + 1'b1;
    end
  end

  assign own0     = (state_q == StGrant0) || (state_q == StDrain0);
  assign own1     = (state_q == StGrant1) || (state_q == StDrain1);
  assign grant0   = (state_q == StGrant0);
  assign grant1   = (state_q == StGrant1);
  assign watchdog = (hold_q == HoldMax);

  assign gnt0 = own0;
  assign gnt1 = own1;

  // Stall is forced low while reset is held so every port output reads quiet.
  assign stall0 = rst & (rd0 | wr0) & ~own0;
  assign stall1 = rst & (rd1 | wr1) & ~own1;

  assign m_rd      = (grant0 & rd0 & ~wr0) | (grant1 & rd1 & ~wr1);
  assign m_wr      = (grant0 & wr0 & ~rd0) | (grant1 & wr1 & ~rd1);
  assign m_addr    = grant0 ? addr0  : (grant1 ? addr1  : '0);
  assign m_data_in = grant0 ? wdata0 : (grant1 ? wdata1 : '0);

  assign rdata0 = own0 ? m_data_out : '0;
  assign rdata1 = own1 ? m_data_out : '0;
  assign busy0  = own0 ? m_busy : '1;
  assign busy1  = own1 ? m_busy : '1;

  assign err0 = (own0 & m_err) | (grant0 & ((rd0 & wr0) | watchdog));
  assign err1 = (own1 & m_err) | (grant1 & ((rd1 & wr1) | watchdog));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic checked against a
// transaction-level ownership model.
module tb_mem_port_arbiter;

  localparam int MAX_HOLD = 64;
  localparam int PRIO_RST = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, rd, wr;
  logic [15:0] addr [2];
  logic [15:0] wdata [2];
  logic [15:0] m_data_out;
  logic [3:0]  m_busy;
  logic        m_err;

  logic [1:0]  gnt, stall, err;
  logic [15:0] rdata [2];
  logic [3:0]  busy [2];
  logic [15:0] m_addr, m_data_in;
  logic        m_rd, m_wr;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: who owns memory, whether the owner is winding down, fairness pointer,
  // and how many cycles the current grant has lasted.
  int own, rr, hold;
  bit drain;

  logic [1:0]  exp_gnt, exp_stall, exp_err;
  logic        exp_mrd, exp_mwr;
  logic [15:0] exp_maddr, exp_mdin;
  logic [15:0] exp_rdata [2];
  logic [3:0]  exp_busy [2];

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req[0]), .req1(req[1]), .rd0(rd[0]), .rd1(rd[1]), .wr0(wr[0]), .wr1(wr[1]),
    .addr0(addr[0]), .addr1(addr[1]), .wdata0(wdata[0]), .wdata1(wdata[1]),
    .gnt0(gnt[0]), .gnt1(gnt[1]), .stall0(stall[0]), .stall1(stall[1]),
    .rdata0(rdata[0]), .rdata1(rdata[1]), .busy0(busy[0]), .busy1(busy[1]),
    .err0(err[0]), .err1(err[1]),
    .m_addr(m_addr), .m_data_in(m_data_in), .m_rd(m_rd), .m_wr(m_wr),
    .m_data_out(m_data_out), .m_busy(m_busy), .m_err(m_err)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    own = -1; drain = 0; rr = PRIO_RST; hold = 0;
  endfunction

  function automatic void model_step();
    int o;
    if (own < 0) begin
      if (req[0] && req[1]) own = rr;
      else if (req[0])      own = 0;
      else if (req[1])      own = 1;
      drain = 0; hold = 0;
    end else if (!drain) begin
      if (!req[own]) drain = 1;
      else if (hold < MAX_HOLD) hold++;
    end else if (m_busy == 4'h0) begin
      o  = 1 - own;
      rr = o;
      if (req[o])        begin own = o; drain = 0; hold = 0; end
      else if (req[own]) begin drain = 0; hold = 0; end
      else               own = -1;
    end
  endfunction

  function automatic void model_expect();
    bit gp;
    gp = (own >= 0) && !drain;
    for (int x = 0; x < 2; x++) begin
      exp_gnt[x]   = (own == x);
      exp_stall[x] = rst && (rd[x] || wr[x]) && (own != x);
      exp_rdata[x] = (own == x) ? m_data_out : 16'h0;
      exp_busy[x]  = (own == x) ? m_busy : 4'hF;
      exp_err[x]   = (own == x) &&
                     (m_err || (!drain && ((rd[x] && wr[x]) || hold >= MAX_HOLD)));
    end
    exp_mrd = 0; exp_mwr = 0; exp_maddr = 16'h0; exp_mdin = 16'h0;
    if (gp) begin
      exp_mrd   = rd[own] && !wr[own];
      exp_mwr   = wr[own] && !rd[own];
      exp_maddr = addr[own];
      exp_mdin  = wdata[own];
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst) model_reset();
    else      model_step();
    #1;
  endtask

  task automatic settle();
    #1;
    model_expect();
  endtask

  task automatic clear_inputs();
    req = 2'b00; rd = 2'b00; wr = 2'b00;
    addr[0] = 16'h0; addr[1] = 16'h0; wdata[0] = 16'h0; wdata[1] = 16'h0;
    m_data_out = 16'h0; m_busy = 4'h0; m_err = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    model_reset();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    model_reset();
    req = 2'b01; rd = 2'b01; addr[0] = 16'h0040; m_busy = 4'h5; m_err = 1'b1;
    tick();
    settle();
    vectors++;
    if ({gnt, stall, err, m_rd, m_wr} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_ctl: got %b want 00000000", {gnt, stall, err, m_rd, m_wr});
    end
    vectors++;
    if ({m_addr, m_data_in, rdata[0], rdata[1]} !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_data: got %h want 0", {m_addr, m_data_in, rdata[0], rdata[1]});
    end
    vectors++;
    if ({busy[0], busy[1]} !== 8'hFF) begin
      miscompares++;
      $display("FAIL reset_busy: got %h want ff", {busy[0], busy[1]});
    end
    m_err = 1'b0; m_busy = 4'h0;
    rst = 1'b1;
    tick();
    settle();
    vectors++;
    if ({gnt, m_rd, m_addr} !== {2'b01, 1'b1, 16'h0040}) begin
      miscompares++;
      $display("FAIL first_grant: got gnt=%b m_rd=%b m_addr=%h want 01 1 0040", gnt, m_rd, m_addr);
    end
  endtask

  task automatic test_drain_handoff();
    do_reset();
    req = 2'b11;
    tick();
    settle();
    vectors++;
    if (gnt !== 2'b01) begin
      miscompares++;
      $display("FAIL contend_first: got %b want 01", gnt);
    end
    req = 2'b10; m_busy = 4'b0100; wr[1] = 1'b1; addr[1] = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      tick();
      settle();
      vectors++;
      if ({gnt, stall[1], m_wr} !== 4'b0110) begin
        miscompares++;
        $display("FAIL drain_wait: got gnt=%b stall1=%b m_wr=%b want 01 1 0", gnt, stall[1], m_wr);
      end
    end
    m_busy = 4'h0;
    tick();
    settle();
    vectors++;
    if ({gnt, stall[1], m_wr, m_addr} !== {2'b10, 1'b0, 1'b1, 16'h1234}) begin
      miscompares++;
      $display("FAIL handoff: got gnt=%b stall1=%b m_wr=%b m_addr=%h want 10 0 1 1234",
               gnt, stall[1], m_wr, m_addr);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] want;
    do_reset();
    req = 2'b11;
    tick();
    for (int t = 0; t < 6; t++) begin
      want = (t % 2 == 0) ? 2'b01 : 2'b10;
      settle();
      vectors++;
      if (gnt !== want) begin
        miscompares++;
        $display("FAIL rr_txn%0d: got %b want %b", t, gnt, want);
      end
      tick();
      tick();
      req[t % 2] = 1'b0;
      tick();
      req[t % 2] = 1'b1;
      tick();
    end
  endtask

  task automatic test_protocol_err();
    do_reset();
    req = 2'b10;
    tick();
    rd = 2'b10; wr = 2'b10; addr[1] = 16'($urandom);
    settle();
    vectors++;
    if ({gnt, m_rd, m_wr, err} !== 6'b10_0_0_10) begin
      miscompares++;
      $display("FAIL rdwr_err: got gnt=%b m_rd=%b m_wr=%b err=%b want 10 0 0 10",
               gnt, m_rd, m_wr, err);
    end
    rd = 2'b00;
    settle();
    vectors++;
    if ({m_wr, err} !== 3'b1_00) begin
      miscompares++;
      $display("FAIL rdwr_clear: got m_wr=%b err=%b want 1 00", m_wr, err);
    end
  endtask

  task automatic test_drain_err();
    req = 2'b00; wr = 2'b00; m_busy = 4'h2;
    tick();
    m_err = 1'b1; m_data_out = 16'hBEEF;
    settle();
    vectors++;
    if ({gnt, err, rdata[1], rdata[0]} !== {2'b10, 2'b10, 16'hBEEF, 16'h0000}) begin
      miscompares++;
      $display("FAIL drain_err: got gnt=%b err=%b rdata1=%h rdata0=%h want 10 10 beef 0000",
               gnt, err, rdata[1], rdata[0]);
    end
    vectors++;
    if ({busy[1], busy[0]} !== 8'h2F) begin
      miscompares++;
      $display("FAIL drain_busy: got %h want 2f", {busy[1], busy[0]});
    end
    m_err = 1'b0; m_busy = 4'h0; m_data_out = 16'h0;
    tick();
  endtask

  task automatic test_watchdog();
    int bad = 0;
    do_reset();
    req = 2'b01;
    tick();
    for (int i = 0; i < MAX_HOLD + 5; i++) begin
      settle();
      vectors++;
      if ({gnt, err[0]} !== {2'b01, 1'(i >= MAX_HOLD)}) begin
        miscompares++;
        $display("FAIL watchdog_c%0d: got gnt=%b err0=%b want 01 %b", i, gnt, err[0],
                 1'(i >= MAX_HOLD));
      end
      tick();
    end
    req = 2'b00;
    settle();
    vectors++;
    if (err[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL watchdog_last: got err0=%b want 1", err[0]);
    end
    tick();
    settle();
    vectors++;
    if ({gnt, err[0]} !== 3'b01_0) begin
      miscompares++;
      $display("FAIL watchdog_drain: got gnt=%b err0=%b want 01 0", gnt, err[0]);
    end
    tick();
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    req = 2'b01;
    tick();
    req = 2'b00;
    tick();
    tick();
    req = 2'b01;
    tick();
    req = 2'b00; m_busy = 4'h3; rd = 2'b01; addr[0] = 16'h00AA;
    tick();
    rst = 1'b0;
    model_reset();
    #1;
    vectors++;
    if ({gnt, m_rd, m_wr, m_addr, busy[0]} !== {2'b00, 2'b00, 16'h0, 4'hF}) begin
      miscompares++;
      $display("FAIL reset_drain: got gnt=%b m_rd=%b m_wr=%b m_addr=%h busy0=%h want 00 0 0 0 f",
               gnt, m_rd, m_wr, m_addr, busy[0]);
    end
    tick();
    rst = 1'b1; m_busy = 4'h0; rd = 2'b00; req = 2'b11;
    tick();
    settle();
    vectors++;
    if (gnt !== 2'b01) begin
      miscompares++;
      $display("FAIL rr_after_reset: got %b want 01", gnt);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(0, 199) != 0);
      if (!rst) model_reset();
      for (int x = 0; x < 2; x++) begin
        if ($urandom_range(0, 7) == 0) req[x] = ~req[x];
        rd[x]    = ($urandom_range(0, 2) == 0);
        wr[x]    = ($urandom_range(0, 3) == 0);
        addr[x]  = 16'($urandom);
        wdata[x] = 16'($urandom);
      end
      m_busy     = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      m_err      = ($urandom_range(0, 9) == 0);
      m_data_out = 16'($urandom);
      settle();
      vectors++;
      if ({gnt, stall, err, m_rd, m_wr} !== {exp_gnt, exp_stall, exp_err, exp_mrd, exp_mwr}) begin
        miscompares++;
        $display("FAIL rand_ctl c%0d: got %b want %b", c, {gnt, stall, err, m_rd, m_wr},
                 {exp_gnt, exp_stall, exp_err, exp_mrd, exp_mwr});
      end
      vectors++;
      if ({m_addr, m_data_in} !== {exp_maddr, exp_mdin}) begin
        miscompares++;
        $display("FAIL rand_mem c%0d: got %h want %h", c, {m_addr, m_data_in},
                 {exp_maddr, exp_mdin});
      end
      vectors++;
      if ({rdata[0], rdata[1], busy[0], busy[1]} !==
          {exp_rdata[0], exp_rdata[1], exp_busy[0], exp_busy[1]}) begin
        miscompares++;
        $display("FAIL rand_route c%0d: got %h want %h", c,
                 {rdata[0], rdata[1], busy[0], busy[1]},
                 {exp_rdata[0], exp_rdata[1], exp_busy[0], exp_busy[1]});
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_drain_handoff();
    test_round_robin();
    test_protocol_err();
    test_drain_err();
    test_watchdog();
    test_reset_mid_drain();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
